// File: rtl/time_update_datapath.sv
// Six-digit BCD HH:MM:SS datapath stepped one digit per pass by the time-update controller.
// Registered outputs; set-port writes yield to controller write-back (requester retries).
module time_update_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       Kc,
  input  logic       La,
  input  logic       Er,
  input  logic       Lb,
  input  logic [1:0] s,
  input  logic       Lr,
  input  logic       Ea,
  input  logic       set_we,
  input  logic [2:0] set_idx,
  input  logic [3:0] set_val,
  output logic       u,
  output logic       set_ack,
  output logic       set_err,
  output logic       day_carry,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);

  logic [3:0] dig [6];
  logic [2:0] k;
  logic [3:0] a, b, y;
  logic       w, c, pend;
  logic [3:0] dig_k;
  logic       set_valid, set_ok, set_rej;

  // H0 may only reach 3 once the tens-of-hours digit is 2
  function automatic logic [3:0] limit(input logic [2:0] idx, input logic [3:0] h1);
    case (idx)
      3'd0, 3'd2: limit = 4'd9;
      3'd1, 3'd3: limit = 4'd5;
      3'd4:       limit = (h1 == 4'd2) ? 4'd3 : 4'd9;
      3'd5:       limit = 4'd2;
      default:    limit = 4'd0;
    endcase
  endfunction

  always_comb begin
    dig_k = '0;
    for (int i = 0; i < 6; i++) begin
      if (k == i[2:0]) dig_k = dig[i];
    end
  end

  assign set_valid = (set_idx <= 3'd5) && (set_val <= limit(set_idx, dig[5]));
  assign set_ok    = set_we && !Lr && set_valid;
  assign set_rej   = set_we && !Lr && !set_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= '0;
      a         <= '0;
      b         <= '0;
      y         <= '0;
      w         <= 1'b0;
      c         <= 1'b0;
      u         <= 1'b0;
      pend      <= 1'b0;
      day_carry <= 1'b0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
      for (int i = 0; i < 6; i++) dig[i] <= '0;
    end else begin
      // Kc starts a pass and consumes the latched tick; extra ticks merge
      if (Kc) begin
        pend <= 1'b0;
        c    <= pend | tick;
        k    <= '0;
        u    <= 1'b0;
      end else begin
        if (tick) pend <= 1'b1;
        if (Ea) begin
          c <= w;
          u <= w && (k != 3'd5);
          k <= (k == 3'd5) ? 3'd0 : k + 3'd1;
        end
      end

      if (La) a <= dig_k;
      if (Lb) b <= limit(k, dig[5]);

      if (Er)              w <= 1'b0;
      else if (s == 2'b01) w <= c && (a == b);

      case (s)
        2'b00:   y <= a;
        2'b01:   y <= c ? ((a == b) ? 4'd0 : a + 4'd1) : a;
        2'b10:   y <= 4'd0;
        default: y <= y;
      endcase

      day_carry <= Lr && (k == 3'd5) && w;
      set_ack   <= set_ok;
      set_err   <= set_rej;

      for (int i = 0; i < 6; i++) begin
        if (Lr && k == i[2:0])                 dig[i] <= y;
        else if (set_ok && set_idx == i[2:0])  dig[i] <= set_val;
      end
    end
  end

  assign hh = {dig[5], dig[4]};
  assign mm = {dig[3], dig[2]};
  assign ss = {dig[1], dig[0]};

endmodule

// File: tb/tb_time_update_datapath.sv
// Directed bench: stimulus pushes cycle-tagged expectations, a negedge monitor pops and compares.
module tb_time_update_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, Kc, La, Er, Lb, Lr, Ea, set_we;
  logic [1:0] s;
  logic [2:0] set_idx;
  logic [3:0] set_val;
  logic       u, set_ack, set_err, day_carry;
  logic [7:0] hh, mm, ss;

  time_update_datapath dut (
    .clk(clk), .reset(reset), .tick(tick), .Kc(Kc), .La(La), .Er(Er), .Lb(Lb),
    .s(s), .Lr(Lr), .Ea(Ea), .set_we(set_we), .set_idx(set_idx), .set_val(set_val),
    .u(u), .set_ack(set_ack), .set_err(set_err), .day_carry(day_carry),
    .hh(hh), .mm(mm), .ss(ss)
  );

  always #5 clk = ~clk;

  localparam int SIG_U = 0, SIG_HH = 1, SIG_MM = 2, SIG_SS = 3,
                 SIG_DC = 4, SIG_ACK = 5, SIG_ERR = 6;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input int sig);
    case (sig)
      SIG_U:   sample = {7'b0, u};
      SIG_HH:  sample = hh;
      SIG_MM:  sample = mm;
      SIG_SS:  sample = ss;
      SIG_DC:  sample = {7'b0, day_carry};
      SIG_ACK: sample = {7'b0, set_ack};
      SIG_ERR: sample = {7'b0, set_err};
      default: sample = 8'hxx;
    endcase
  endfunction

  // Monitor: compare every expectation due at or before the current cycle
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = sample(e.sig);
      checks++;
      if (act === e.val) passes++;
      else $display("FAIL %s @cyc %0d: got %h, expected %h", e.name, cyc, act, e.val);
    end
  end

  task automatic expect_v(input string n, input int sig, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic clr();
    tick = 0; Kc = 0; La = 0; Er = 0; Lb = 0; Lr = 0; Ea = 0;
    s = 2'b11; set_we = 0; set_idx = 3'd0; set_val = 4'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_time(input string n, input logic [7:0] eh, input logic [7:0] em,
                             input logic [7:0] es);
    expect_v({n, "_hh"}, SIG_HH, eh);
    expect_v({n, "_mm"}, SIG_MM, em);
    expect_v({n, "_ss"}, SIG_SS, es);
  endtask

  task automatic digit_pass(input string n, input logic eu, input logic edc);
    La = 1; Er = 1; step();
    Lb = 1; step();
    s = 2'b01; step();
    Lr = 1; Ea = 1; step();
    expect_v({n, "_u"}, SIG_U, {7'b0, eu});
    expect_v({n, "_dc"}, SIG_DC, {7'b0, edc});
  endtask

  task automatic start_pass(input logic with_tick);
    if (with_tick) begin
      tick = 1; step();
    end
    Kc = 1; step();
  endtask

  task automatic set_d(input string n, input logic [2:0] idx, input logic [3:0] val,
                       input logic ok);
    set_we = 1; set_idx = idx; set_val = val; step();
    expect_v({n, "_ack"}, SIG_ACK, {7'b0, ok});
    expect_v({n, "_err"}, SIG_ERR, {7'b0, !ok});
  endtask

  task automatic set_time(input string n, input logic [7:0] t_h, input logic [7:0] t_m,
                          input logic [7:0] t_s);
    set_d(n, 3'd5, t_h[7:4], 1'b1);
    set_d(n, 3'd4, t_h[3:0], 1'b1);
    set_d(n, 3'd3, t_m[7:4], 1'b1);
    set_d(n, 3'd2, t_m[3:0], 1'b1);
    set_d(n, 3'd1, t_s[7:4], 1'b1);
    set_d(n, 3'd0, t_s[3:0], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    checks++;
    if ({hh, mm, ss} === 24'h000000) passes++;
    else $display("FAIL rst_now: got %h%h%h, expected 000000", hh, mm, ss);
    expect_time("rst", 8'h00, 8'h00, 8'h00);
    expect_v("rst_u", SIG_U, 8'h0);
    expect_v("rst_dc", SIG_DC, 8'h0);
    expect_v("rst_ack", SIG_ACK, 8'h0);
    expect_v("rst_err", SIG_ERR, 8'h0);

    // 00:00:00 -> 00:00:01
    start_pass(1'b1);
    digit_pass("t1_s0", 1'b0, 1'b0);
    checks++;
    if (ss === 8'h01) passes++;
    else $display("FAIL t1_now_ss: got %h, expected 01", ss);
    expect_time("t1", 8'h00, 8'h00, 8'h01);

    // 00:00:59 -> 00:01:00
    set_d("p59_s0", 3'd0, 4'd9, 1'b1);
    set_d("p59_s1", 3'd1, 4'd5, 1'b1);
    expect_v("p59_ss", SIG_SS, 8'h59);
    start_pass(1'b1);
    digit_pass("m_s0", 1'b1, 1'b0);
    digit_pass("m_s1", 1'b1, 1'b0);
    digit_pass("m_m0", 1'b0, 1'b0);
    expect_time("min", 8'h00, 8'h01, 8'h00);

    // 23:59:59 -> 00:00:00 with day_carry on the H1 write
    set_time("p235959", 8'h23, 8'h59, 8'h59);
    expect_time("p235959", 8'h23, 8'h59, 8'h59);
    start_pass(1'b1);
    for (int i = 0; i < 5; i++) digit_pass("mid_d", 1'b1, 1'b0);
    digit_pass("mid_h1", 1'b0, 1'b1);
    checks++;
    if (day_carry === 1'b1) passes++;
    else $display("FAIL mid_now_dc: got %b, expected 1", day_carry);
    expect_time("mid", 8'h00, 8'h00, 8'h00);
    step();
    expect_v("mid_dc_width", SIG_DC, 8'h0);

    // 19:59:59 -> 20:00:00
    set_time("p195959", 8'h19, 8'h59, 8'h59);
    start_pass(1'b1);
    for (int i = 0; i < 5; i++) digit_pass("h19_d", 1'b1, 1'b0);
    digit_pass("h19_h1", 1'b0, 1'b0);
    checks++;
    if (hh === 8'h20) passes++;
    else $display("FAIL h20_now_hh: got %h, expected 20", hh);
    expect_time("h20", 8'h20, 8'h00, 8'h00);

    // Set-port rejects and write-back contention
    set_d("bad_h0", 3'd4, 4'd5, 1'b0);
    expect_v("bad_h0_hh", SIG_HH, 8'h20);
    step();
    expect_v("err_width", SIG_ERR, 8'h0);
    set_d("bad_idx", 3'd6, 4'd0, 1'b0);
    set_d("bad_s0", 3'd0, 4'hA, 1'b0);
    set_we = 1; set_idx = 3'd0; set_val = 4'd7; Lr = 1; step();
    expect_v("blk_ack", SIG_ACK, 8'h0);
    expect_v("blk_err", SIG_ERR, 8'h0);
    set_d("retry", 3'd0, 4'd7, 1'b1);
    expect_v("retry_ss", SIG_SS, 8'h07);
    step();
    expect_v("ack_width", SIG_ACK, 8'h0);

    // Pass without a pending tick leaves time unchanged
    start_pass(1'b0);
    digit_pass("notick", 1'b0, 1'b0);
    expect_time("notick", 8'h20, 8'h00, 8'h07);

    // Reset between La and Lr aborts the pass and drops the pending tick
    start_pass(1'b1);
    La = 1; Er = 1; step();
    Lb = 1; step();
    reset = 1; step();
    reset = 0;
    expect_time("abort", 8'h00, 8'h00, 8'h00);
    expect_v("abort_u", SIG_U, 8'h0);
    expect_v("abort_dc", SIG_DC, 8'h0);
    start_pass(1'b0);
    digit_pass("post_rst", 1'b0, 1'b0);
    checks++;
    if (ss === 8'h00) passes++;
    else $display("FAIL post_rst_now_ss: got %h, expected 00", ss);
    expect_time("post_rst", 8'h00, 8'h00, 8'h00);

    step();
    step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: never checked, expected %h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
